// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared one-time-pad constants and LFSR step function
package otp_pkg;

    localparam logic [7:0] OTP_SEED = 8'h01;
    // Feedback taps s[7], s[5], s[4], s[3]
    localparam logic [7:0] OTP_TAPS = 8'hB8;
    localparam int OTP_IDX_W = 3;
    localparam logic [OTP_IDX_W-1:0] OTP_FIRST_IDX = 3'd1;

    function automatic logic [7:0] otp_lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & OTP_TAPS)};
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// rtl/otp_lfsr.sv - 8-bit Fibonacci pad generator, load has priority over step
module otp_lfsr
    import otp_pkg::*;
#(
    parameter logic [7:0] SEED = OTP_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= SEED;
        end else if (step) begin
            r_state <= otp_lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/otp_decryptor.sv
// rtl/otp_decryptor.sv - one-time-pad decryptor with index check and pad replay ring
module otp_decryptor
    import otp_pkg::*;
#(
    parameter logic [7:0] SEED  = OTP_SEED,
    parameter int         DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 ct_valid,
    input  logic [7:0]           ct_data,
    input  logic [OTP_IDX_W-1:0] ct_index,
    input  logic                 replay,
    input  logic                 resync,
    output logic                 pt_valid,
    output logic [7:0]           pt_data,
    output logic                 pt_err,
    output logic [OTP_IDX_W-1:0] exp_index,
    output logic                 desync
);

    logic                 r_pt_valid;
    logic [7:0]           r_pt_data;
    logic                 r_pt_err;
    logic [OTP_IDX_W-1:0] r_exp_index;
    logic                 r_desync;
    logic [7:0]           r_pad [DEPTH];
    logic [DEPTH-1:0]     r_valid;

    logic       w_resync;
    logic       w_accept;
    logic       w_match;
    logic       w_step;
    logic [7:0] w_pad;

    // Resync swallows any byte arriving in the same cycle
    assign w_resync = ena & resync;
    assign w_accept = ena & ct_valid & ~resync;
    assign w_match  = (ct_index == r_exp_index);
    assign w_step   = w_accept & ~replay & w_match;

    otp_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_resync),
        .step  (w_step),
        .state (w_pad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt_valid  <= 1'b0;
            r_pt_data   <= 8'h00;
            r_pt_err    <= 1'b0;
            r_exp_index <= OTP_FIRST_IDX;
            r_desync    <= 1'b0;
            r_valid     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pad[i] <= 8'h00;
            end
        end else begin
            r_pt_valid <= w_accept;
            if (w_resync) begin
                r_exp_index <= OTP_FIRST_IDX;
                r_valid     <= '0;
                r_desync    <= 1'b0;
            end else if (w_accept) begin
                if (replay) begin
                    if (r_valid[ct_index]) begin
                        r_pt_data <= ct_data ^ r_pad[ct_index];
                        r_pt_err  <= 1'b0;
                    end else begin
                        r_pt_data <= 8'h00;
                        r_pt_err  <= 1'b1;
                    end
                end else if (w_match) begin
                    r_pt_data            <= ct_data ^ w_pad;
                    r_pt_err             <= 1'b0;
                    r_pad[r_exp_index]   <= w_pad;
                    r_valid[r_exp_index] <= 1'b1;
                    r_exp_index          <= r_exp_index + 1'b1;
                end else begin
                    r_pt_data <= 8'h00;
                    r_pt_err  <= 1'b1;
                    r_desync  <= 1'b1;
                end
            end
        end
    end

    assign pt_valid  = r_pt_valid;
    assign pt_data   = r_pt_data;
    assign pt_err    = r_pt_err;
    assign exp_index = r_exp_index;
    assign desync    = r_desync;

endmodule

// File: tb/tb_otp_decryptor.sv
// tb/tb_otp_decryptor.sv - self-checking bench for otp_decryptor
module tb_otp_decryptor;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic [2:0] ct_index;
    logic       replay;
    logic       resync;
    logic       pt_valid;
    logic [7:0] pt_data;
    logic       pt_err;
    logic [2:0] exp_index;
    logic       desync;

    int checks   = 0;
    int failures = 0;

    otp_decryptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .ct_valid  (ct_valid),
        .ct_data   (ct_data),
        .ct_index  (ct_index),
        .replay    (replay),
        .resync    (resync),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_err    (pt_err),
        .exp_index (exp_index),
        .desync    (desync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ena;
        logic       vld;
        logic [7:0] data;
        logic [2:0] idx;
        logic       rep;
        logic       rsy;
        logic       e_pv;
        logic [7:0] e_pd;
        logic       e_err;
        logic [2:0] e_idx;
        logic       e_ds;
    } vec_t;

    vec_t vt[$];

    // Reference model: pad sequence as a list, ring as arrays
    int         seq [2048];
    int         m_count;
    logic [7:0] m_ring [8];
    bit         m_rv [8];
    bit         m_ds;
    bit         m_pv;
    logic [7:0] m_pd;
    bit         m_err;

    function automatic int lfsr_succ(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) & 255) | fb;
    endfunction

    function automatic int m_exp();
        return (1 + m_count) % 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ds    = 0;
        m_pv    = 0;
        m_pd    = 8'h00;
        m_err   = 0;
        for (int i = 0; i < 8; i++) begin
            m_rv[i]   = 0;
            m_ring[i] = 8'h00;
        end
    endtask

    task automatic model_step(input bit e, v, input logic [7:0] d, input logic [2:0] ix, input bit rp, rs);
        m_pv = 0;
        if (!e) return;
        if (rs) begin
            m_count = 0;
            m_ds    = 0;
            for (int i = 0; i < 8; i++) m_rv[i] = 0;
        end else if (v) begin
            m_pv = 1;
            if (rp) begin
                if (m_rv[ix]) begin
                    m_pd  = d ^ m_ring[ix];
                    m_err = 0;
                end else begin
                    m_pd  = 8'h00;
                    m_err = 1;
                end
            end else if (int'(ix) == m_exp()) begin
                m_pd        = d ^ 8'(seq[m_count]);
                m_err       = 0;
                m_ring[ix]  = 8'(seq[m_count]);
                m_rv[ix]    = 1;
                m_count++;
            end else begin
                m_pd  = 8'h00;
                m_err = 1;
                m_ds  = 1;
            end
        end
    endtask

    task automatic drive(input bit e, v, input logic [7:0] d, input logic [2:0] ix, input bit rp, rs);
        ena      = e;
        ct_valid = v;
        ct_data  = d;
        ct_index = ix;
        replay   = rp;
        resync   = rs;
        @(posedge clk);
        #1;
        model_step(e, v, d, ix, rp, rs);
    endtask

    task automatic do_reset();
        ena = 0; ct_valid = 0; ct_data = 0; ct_index = 0; replay = 0; resync = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input vec_t v);
        vt.push_back(v);
    endtask

    initial begin
        int s;
        s = 8'h01;
        for (int i = 0; i < 2048; i++) begin
            seq[i] = s;
            s = lfsr_succ(s);
        end

        //    rst ena vld data   idx rep rsy  pv pd     err idx ds
        add('{1, 1, 1, 8'h40, 1, 0, 0, 1, 8'h41, 0, 2, 0});
        add('{0, 1, 1, 8'hFF, 1, 1, 0, 1, 8'hFE, 0, 2, 0});
        add('{0, 1, 1, 8'h12, 6, 1, 0, 1, 8'h00, 1, 2, 0});
        add('{0, 1, 1, 8'h33, 5, 0, 0, 1, 8'h00, 1, 2, 1});
        add('{0, 1, 1, 8'h00, 2, 0, 0, 1, 8'h02, 0, 3, 1});
        add('{0, 0, 1, 8'h55, 3, 0, 0, 0, 8'h02, 0, 3, 1});
        add('{0, 1, 0, 8'h00, 3, 0, 0, 0, 8'h02, 0, 3, 1});
        add('{0, 1, 1, 8'h00, 3, 0, 0, 1, 8'h04, 0, 4, 1});
        add('{0, 1, 1, 8'h00, 4, 0, 1, 0, 8'h04, 0, 1, 0});
        add('{0, 1, 1, 8'h40, 1, 0, 0, 1, 8'h41, 0, 2, 0});
        add('{0, 1, 1, 8'h00, 2, 1, 0, 1, 8'h00, 1, 2, 0});
        // Wrap through all eight slots, then overwrite slot 1
        add('{1, 1, 1, 8'h00, 1, 0, 0, 1, 8'h01, 0, 2, 0});
        add('{0, 1, 1, 8'h00, 2, 0, 0, 1, 8'h02, 0, 3, 0});
        add('{0, 1, 1, 8'h00, 3, 0, 0, 1, 8'h04, 0, 4, 0});
        add('{0, 1, 1, 8'h00, 4, 0, 0, 1, 8'h08, 0, 5, 0});
        add('{0, 1, 1, 8'h00, 5, 0, 0, 1, 8'h11, 0, 6, 0});
        add('{0, 1, 1, 8'h00, 6, 0, 0, 1, 8'h23, 0, 7, 0});
        add('{0, 1, 1, 8'h00, 7, 0, 0, 1, 8'h47, 0, 0, 0});
        add('{0, 1, 1, 8'h00, 0, 0, 0, 1, 8'h8E, 0, 1, 0});
        add('{0, 1, 1, 8'h00, 1, 0, 0, 1, 8'h1C, 0, 2, 0});
        add('{0, 1, 1, 8'h00, 1, 1, 0, 1, 8'h1C, 0, 2, 0});
        add('{0, 1, 1, 8'hFF, 0, 1, 0, 1, 8'h71, 0, 2, 0});

        rst_n = 1'b1;
        do_reset();
        chk("reset_pt_valid", 32'(pt_valid), 0);
        chk("reset_pt_data", 32'(pt_data), 0);
        chk("reset_pt_err", 32'(pt_err), 0);
        chk("reset_exp_index", 32'(exp_index), 1);
        chk("reset_desync", 32'(desync), 0);

        for (int k = 0; k < vt.size(); k++) begin
            if (vt[k].rst) do_reset();
            drive(vt[k].ena, vt[k].vld, vt[k].data, vt[k].idx, vt[k].rep, vt[k].rsy);
            chk($sformatf("vec%0d_pt_valid", k), 32'(pt_valid), 32'(vt[k].e_pv));
            chk($sformatf("vec%0d_pt_data", k), 32'(pt_data), 32'(vt[k].e_pd));
            if (vt[k].e_pv) chk($sformatf("vec%0d_pt_err", k), 32'(pt_err), 32'(vt[k].e_err));
            chk($sformatf("vec%0d_exp_index", k), 32'(exp_index), 32'(vt[k].e_idx));
            chk($sformatf("vec%0d_desync", k), 32'(desync), 32'(vt[k].e_ds));
        end

        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit         e, v, rp, rs;
            logic [7:0] d;
            logic [2:0] ix;
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 19) < 17);
            rp = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 39) == 0);
            d  = 8'($urandom);
            ix = ($urandom_range(0, 9) < 7) ? 3'(m_exp()) : 3'($urandom);
            drive(e, v, d, ix, rp, rs);
            chk($sformatf("rnd%0d_pt_valid", n), 32'(pt_valid), 32'(m_pv));
            chk($sformatf("rnd%0d_pt_data", n), 32'(pt_data), 32'(m_pd));
            chk($sformatf("rnd%0d_pt_err", n), 32'(pt_err), 32'(m_err));
            chk($sformatf("rnd%0d_exp_index", n), 32'(exp_index), 32'(m_exp()));
            chk($sformatf("rnd%0d_desync", n), 32'(desync), 32'(m_ds));
        end

        // Asynchronous reset mid-stream, observed between clock edges
        drive(1, 1, 8'h00, 3'(m_exp() + 3), 0, 0);
        drive(1, 1, 8'h5A, 3'(m_exp()), 0, 0);
        chk("pre_areset_desync", 32'(desync), 1);
        chk("pre_areset_pt_valid", 32'(pt_valid), 1);
        ena = 1; ct_valid = 1; ct_index = 3'(m_exp()); replay = 0; resync = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_pt_valid", 32'(pt_valid), 0);
        chk("areset_pt_data", 32'(pt_data), 0);
        chk("areset_pt_err", 32'(pt_err), 0);
        chk("areset_exp_index", 32'(exp_index), 1);
        chk("areset_desync", 32'(desync), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1, 1, 8'h40, 1, 0, 0);
        chk("post_areset_pt_data", 32'(pt_data), 32'h41);
        chk("post_areset_exp_index", 32'(exp_index), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
